dmem_responder: RTL and testbench

Word-addressed data-memory responder that answers the CPU core's load/store port. It samples the core's request (`mem`, `mem_read`, `addr`, write data) and performs a word write or read against internal storage after a fixed, parameterised access latency. It returns read data together with a one-cycle `ready` pulse and flags misaligned or out-of-range accesses. It sits between the core's memory port and the SoC; the core drives requests on `clk` negedge and this block operates on `clk` posedge.

---
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_responder.sv | 104 ++++++++++
 tb/tb_dmem_responder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store port between the CPU core (master) and the data-memory responder (slave).
interface dmem_if;
    logic        mem;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output mem, mem_read, addr, data_out,
        input  data_in, ready, err, busy
    );

    modport slave (
        input  mem, mem_read, addr, data_out,
        output data_in, ready, err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory behind the core's load/store port.
// Each request is latched, executed LATENCY cycles later and completed with a
// one-cycle ready (plus err for misaligned/out-of-range addresses).
//
// state  | meaning
// IDLE   | waiting for mem=1
// ACCESS | counting down the access latency, executes when countdown hits 0
// DONE   | ready/err pulse; returns to IDLE, or accepts the next request
//        | on this same edge when mem is still held (IDLE re-entry accept)
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    dmem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          rd_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          ready_q;
    logic          err_q;
    logic          busy_q;

    logic [31:0]   storage [DEPTH];

    logic [AW-1:0] idx;
    logic          fault;
    logic          exec;

    assign idx   = addr_q[AW+1:2];
    assign fault = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
    assign exec  = (state == ACCESS) && (cnt == '0);

    assign bus.data_in = rdata_q;
    assign bus.ready   = ready_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;

    // Request sequencing, latency countdown and registered completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.mem) begin
                        rd_q    <= bus.mem_read;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.data_out;
                        cnt     <= CW'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state   <= ACCESS;
                    end else begin
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        ready_q <= 1'b1;
                        err_q   <= fault;
                        if (rd_q) begin
                            rdata_q <= fault ? 32'h0 : storage[idx];
                        end
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage write at the execute edge; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (exec && !rd_q && !fault) begin
            storage[idx] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (LATENCY 2 and 1) driven with directed and
// random requests; an edge-indexed reference model predicts every completion.
module tb_dmem_responder;
    localparam int DEPTH = 1024;

    typedef struct {
        int          due;
        bit          rd;
        bit          flt;
        int          idx;
        logic [31:0] wd;
    } req_t;

    logic clk = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : 1;

        dmem_if ifc ();

        logic        rst_d  = 1'b0;
        logic        mem_d  = 1'b0;
        logic        rd_d   = 1'b0;
        logic [31:0] addr_d = '0;
        logic [31:0] wd_d   = '0;
        bit          done   = 1'b0;

        assign ifc.mem      = mem_d;
        assign ifc.mem_read = rd_d;
        assign ifc.addr     = addr_d;
        assign ifc.data_out = wd_d;

        dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
            .clk  (clk),
            .rst_n(rst_d),
            .bus  (ifc.slave)
        );

        req_t        q[$];
        logic [31:0] ref_mem [int];
        int          ecnt     = 0;
        int          free_at  = 0;
        logic [31:0] exp_data = '0;

        task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL %s (LATENCY=%0d, edge %0d): got %h, expected %h",
                         nm, LAT, ecnt, act, exp);
            end
        endtask

        task automatic drive(input bit m, input bit r, input logic [31:0] a,
                             input logic [31:0] d, input int n);
            repeat (n) begin
                @(negedge clk);
                mem_d  = m;
                rd_d   = r;
                addr_d = a;
                wd_d   = d;
            end
        endtask

        // Reference model and monitor, evaluated 1 time unit after every rising edge.
        initial begin
            req_t e;
            bit   exp_rdy;
            bit   exp_err;
            forever begin
                @(posedge clk);
                #1;
                ecnt++;
                exp_rdy = 1'b0;
                exp_err = 1'b0;
                if (!rst_d) begin
                    q.delete();
                    free_at  = 0;
                    exp_data = '0;
                end else begin
                    if (q.size() > 0 && q[0].due == ecnt) begin
                        e = q.pop_front();
                        exp_rdy = 1'b1;
                        exp_err = e.flt;
                        if (e.rd) begin
                            if (e.flt) exp_data = '0;
                            else exp_data = ref_mem.exists(e.idx) ? ref_mem[e.idx] : 32'h0;
                        end else if (!e.flt) begin
                            ref_mem[e.idx] = e.wd;
                        end
                    end
                    if (mem_d && ecnt >= free_at) begin
                        e.due = ecnt + LAT;
                        e.rd  = rd_d;
                        e.flt = (addr_d % 4 != 0) || (addr_d >= 32'(4 * DEPTH));
                        e.idx = int'(addr_d / 4);
                        e.wd  = wd_d;
                        q.push_back(e);
                        free_at = ecnt + LAT + 1;
                    end
                end
                chk("ready",   32'(ifc.ready), 32'(exp_rdy));
                chk("err",     32'(ifc.err),   32'(exp_err));
                chk("busy",    32'(ifc.busy),  32'(ecnt < free_at));
                chk("data_in", ifc.data_in,    exp_data);
            end
        end

        // Stimulus: directed scenarios followed by randomized traffic.
        initial begin
            int sel;
            logic [31:0] a;
            drive(1, 1, 32'h0, 32'h0, 3);
            @(negedge clk);
            rst_d = 1'b1;
            drive(0, 0, 32'h0, 32'h0, LAT + 2);
            drive(1, 0, 32'h10, 32'hDEADBEEF, 1);
            drive(0, 0, 32'h0, 32'h0, LAT + 2);
            drive(1, 1, 32'h10, 32'h0, 1);
            drive(0, 0, 32'h0, 32'h0, LAT + 2);
            drive(1, 0, 32'h12, 32'hCAFEF00D, 1);
            drive(0, 0, 32'h0, 32'h0, LAT + 2);
            drive(1, 1, 32'h10, 32'h0, 1);
            drive(0, 0, 32'h0, 32'h0, LAT + 2);
            drive(1, 1, 32'(4 * DEPTH), 32'h0, 1);
            drive(0, 0, 32'h0, 32'h0, LAT + 2);
            drive(1, 0, 32'h0, 32'hA5A5A5A5, 1);
            drive(0, 0, 32'h0, 32'h0, LAT + 2);
            drive(1, 0, 32'h4, 32'h5A5A5A5A, 1);
            drive(0, 0, 32'h0, 32'h0, LAT + 2);
            drive(1, 1, 32'h0, 32'h0, 1);
            drive(1, 1, 32'h4, 32'h0, LAT + 1);
            drive(0, 0, 32'h0, 32'h0, LAT + 2);
            drive(1, 0, 32'h20, 32'h12345678, 1);
            @(negedge clk);
            mem_d = 1'b0;
            rst_d = 1'b0;
            drive(0, 0, 32'h0, 32'h0, 2);
            @(negedge clk);
            rst_d = 1'b1;
            drive(1, 1, 32'h20, 32'h0, 1);
            drive(0, 0, 32'h0, 32'h0, LAT + 2);
            drive(1, 1, 32'h0, 32'h0, 4 * (LAT + 1));
            drive(0, 0, 32'h0, 32'h0, LAT + 2);
            for (int i = 0; i < 400; i++) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 7)       a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                else if (sel == 7) a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
                else if (sel == 8) a = 32'(4 * DEPTH) + {$urandom_range(0, 255), 2'b00};
                else               a = $urandom;
                drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, a, $urandom, 1);
                rst_d = ($urandom_range(0, 59) != 0);
            end
            @(negedge clk);
            rst_d = 1'b1;
            drive(0, 0, 32'h0, 32'h0, LAT + 3);
            done = 1'b1;
        end
    end

    // Completion wait with a bounded cycle budget, then the summary.
    initial begin
        int cyc;
        cyc = 0;
        while (!(g_dut[0].done && g_dut[1].done) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        if (!(g_dut[0].done && g_dut[1].done)) begin
            n_err++;
            $display("FAIL timeout: stimulus incomplete after %0d cycles, expected completion", cyc);
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
